// File: rtl/vga_bounce_renderer.sv
// Colour stage after the VGA timing generator: draws a bouncing box over a background.
// Two-strobe pipeline for rgb and syncs; box moves once per frame on i_animate.
module vga_bounce_renderer #(
  parameter int          SIZE    = 32,
  parameter int          SPEED   = 2,
  parameter int          X_START = 100,
  parameter int          Y_START = 60,
  parameter logic [11:0] BG_RGB  = 12'h013
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_blanking,
  input  logic       i_animate,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_pause,
  output logic       o_hs,
  output logic       o_vs,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic [7:0] o_bounces
);

  localparam logic [10:0] X_MAX  = 11'(640 - SIZE);
  localparam logic [10:0] Y_MAX  = 11'(480 - SIZE);
  localparam logic [10:0] SZ     = 11'(SIZE);
  localparam logic [10:0] SP     = 11'(SPEED);
  localparam logic [10:0] X_INIT = 11'(X_START);
  localparam logic [10:0] Y_INIT = 11'(Y_START);

  logic [10:0] bx, by, bx_next, by_next;
  logic        dir_x, dir_y, dir_x_next, dir_y_next;
  logic        flip_x, flip_y;
  logic [1:0]  ci;
  logic [7:0]  bounces;

  logic        s1_in_box, s1_blank, s1_hs, s1_vs;
  logic [11:0] rgb;
  logic [10:0] px, py;
  logic        in_box;
  logic [11:0] box_rgb;

  function automatic logic [11:0] pal(input logic [1:0] idx);
    case (idx)
      2'd0:    pal = 12'hF00;
      2'd1:    pal = 12'h0F0;
      2'd2:    pal = 12'h00F;
      default: pal = 12'hFF0;
    endcase
  endfunction

  assign px      = {1'b0, i_x};
  assign py      = {2'b00, i_y};
  assign in_box  = (px >= bx) && (px < bx + SZ) && (py >= by) && (py < by + SZ);
  assign box_rgb = pal(ci);

  // dir = 1 means moving towards larger coordinates; edges clamp and flip.
  always_comb begin
    bx_next    = bx;
    dir_x_next = dir_x;
    flip_x     = 1'b0;
    if (dir_x) begin
      if (bx + SP >= X_MAX) begin
        bx_next    = X_MAX;
        dir_x_next = 1'b0;
        flip_x     = 1'b1;
      end else begin
        bx_next = bx + SP;
      end
    end else begin
      if (bx <= SP) begin
        bx_next    = '0;
        dir_x_next = 1'b1;
        flip_x     = 1'b1;
      end else begin
        bx_next = bx - SP;
      end
    end
  end

  always_comb begin
    by_next    = by;
    dir_y_next = dir_y;
    flip_y     = 1'b0;
    if (dir_y) begin
      if (by + SP >= Y_MAX) begin
        by_next    = Y_MAX;
        dir_y_next = 1'b0;
        flip_y     = 1'b1;
      end else begin
        by_next = by + SP;
      end
    end else begin
      if (by <= SP) begin
        by_next    = '0;
        dir_y_next = 1'b1;
        flip_y     = 1'b1;
      end else begin
        by_next = by - SP;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bx        <= X_INIT;
      by        <= Y_INIT;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      ci        <= '0;
      bounces   <= '0;
      s1_in_box <= 1'b0;
      s1_blank  <= 1'b1;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      rgb       <= '0;
      o_hs      <= 1'b1;
      o_vs      <= 1'b1;
    end else if (i_pix_stb) begin
      s1_in_box <= in_box;
      s1_blank  <= i_blanking;
      s1_hs     <= i_hs;
      s1_vs     <= i_vs;
      rgb       <= s1_blank ? 12'h000 : (s1_in_box ? box_rgb : BG_RGB);
      o_hs      <= s1_hs;
      o_vs      <= s1_vs;
      if (i_animate && !i_pause) begin
        bx    <= bx_next;
        by    <= by_next;
        dir_x <= dir_x_next;
        dir_y <= dir_y_next;
        // A corner hit flips both axes but is a single bounce event.
        if (flip_x || flip_y) begin
          ci      <= ci + 2'd1;
          bounces <= bounces + 8'd1;
        end
      end
    end
  end

  assign o_r       = rgb[11:8];
  assign o_g       = rgb[7:4];
  assign o_b       = rgb[3:0];
  assign o_bounces = bounces;

endmodule
